// File: rtl/gpio_bus_master_if.sv
// CPU-side request/response handshake of the GPIO bus master.
// The requester uses the master modport, the bus master block uses the slave modport.
interface gpio_bus_master_if #(
    parameter int unsigned DATA_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic              req_dir;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_write, req_dir, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_dir, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/gpio_bus_master.sv
// Initiator for the GPIO peripheral bus: one CPU request becomes a timed CS/strobe
// transaction on the shared tri-state data_bus, answered by a one-cycle response.
module gpio_bus_master #(
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned IO_N         = 13,
    parameter int unsigned SETUP_CYCLES = 1,
    parameter int unsigned TURNAROUND   = 1
) (
    input  logic                clock,
    input  logic                reset,
    gpio_bus_master_if.slave    req_if,
    output logic                busy,
    output logic [IO_N-1:0]     dir_shadow,
    inout  wire  [DATA_W-1:0]   data_bus,
    output logic                CS,
    output logic                mem_read,
    output logic                mem_write,
    output logic                LOAD_DIR
);

    localparam int unsigned CNT_MAX = ((SETUP_CYCLES > TURNAROUND) ? SETUP_CYCLES : TURNAROUND) - 1;
    localparam int unsigned CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam logic [DATA_W-1:0] IO_MASK = {{(DATA_W-IO_N){1'b0}}, {IO_N{1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_RELEASE,
        S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              write_q, write_d;
    logic              dir_q, dir_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q;

    logic              in_access;
    logic              cs_d, mem_read_d, mem_write_d, load_dir_d;
    logic              busy_d, ready_d;
    logic              resp_valid_d, resp_err_d;
    logic [DATA_W-1:0] resp_rdata_d;

    // Only this block drives the bus, and only during a write access.
    assign data_bus = (CS && mem_write) ? wdata_q : {DATA_W{1'bz}};

    // Next state, latched request and next values of the registered outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        dir_d   = dir_q;
        err_d   = err_q;
        wdata_d = wdata_q;

        case (state_q)
            S_IDLE: begin
                if (req_if.req_valid && req_if.req_ready) begin
                    write_d = req_if.req_write;
                    dir_d   = req_if.req_dir;
                    wdata_d = req_if.req_wdata;
                    if (!req_if.req_write && req_if.req_dir) begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        err_d   = 1'b0;
                        cnt_d   = CNT_W'(SETUP_CYCLES - 1);
                        state_d = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = S_STROBE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_STROBE: begin
                cnt_d   = CNT_W'(TURNAROUND - 1);
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they register glitch-free.
        in_access    = (state_d == S_SETUP) || (state_d == S_STROBE);
        cs_d         = in_access;
        load_dir_d   = in_access && dir_d;
        mem_write_d  = in_access && write_d;
        mem_read_d   = in_access && !write_d;
        busy_d       = (state_d != S_IDLE);
        ready_d      = (state_d == S_IDLE);
        resp_valid_d = (state_d == S_RESP);
        resp_err_d   = resp_valid_d && err_d;
        resp_rdata_d = (resp_valid_d && !err_d && !write_d) ? rdata_q : '0;
    end

    // State, request latch and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q           <= S_IDLE;
            cnt_q             <= '0;
            write_q           <= 1'b0;
            dir_q             <= 1'b0;
            err_q             <= 1'b0;
            wdata_q           <= '0;
            CS                <= 1'b0;
            mem_read          <= 1'b0;
            mem_write         <= 1'b0;
            LOAD_DIR          <= 1'b0;
            busy              <= 1'b0;
            req_if.req_ready  <= 1'b1;
            req_if.resp_valid <= 1'b0;
            req_if.resp_err   <= 1'b0;
            req_if.resp_rdata <= '0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            write_q           <= write_d;
            dir_q             <= dir_d;
            err_q             <= err_d;
            wdata_q           <= wdata_d;
            CS                <= cs_d;
            mem_read          <= mem_read_d;
            mem_write         <= mem_write_d;
            LOAD_DIR          <= load_dir_d;
            busy              <= busy_d;
            req_if.req_ready  <= ready_d;
            req_if.resp_valid <= resp_valid_d;
            req_if.resp_err   <= resp_err_d;
            req_if.resp_rdata <= resp_rdata_d;
        end
    end

    // The peripheral samples or updates at the closing edge of the strobe cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdata_q    <= '0;
            dir_shadow <= '0;
        end else if (state_q == S_STROBE) begin
            if (!write_q) begin
                rdata_q <= data_bus & IO_MASK;
            end else if (dir_q) begin
                dir_shadow <= wdata_q[IO_N-1:0];
            end
        end
    end

endmodule
